// File: rtl/sdio_host_cmd.sv
// SDIO host command-line engine: divides the system clock into sd_clock, sends a
// CRC7-protected 48-bit command frame on CMD and optionally captures the response.
`timescale 1ns/1ps
module sdio_host_cmd #(
  parameter int CLK_DIV      = 4,
  parameter int RESP_TIMEOUT = 64,
  parameter int GAP_CYCLES   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_expect_resp,
  output logic        busy,
  output logic [37:0] resp_data,
  output logic        resp_strobe,
  output logic        resp_crc_error,
  output logic        resp_timeout,
  output logic        sd_clock,
  inout  wire         sd_serial
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_GAP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic             r_sdclk;
  logic             w_tc;
  logic             w_rise;
  logic             w_fall;
  logic             w_cnt_ev;
  logic [CNT_W-1:0] r_cnt;
  logic [47:0]      r_frame;
  logic             r_expect;
  logic             r_oe;
  logic             r_out;
  logic [45:0]      r_rx;
  logic [46:0]      w_rx_nxt;
  logic             w_line;
  logic             w_rx_err;
  logic [37:0]      r_resp_data;
  logic             r_strobe;
  logic             r_crc_err;
  logic             r_tmo;

  function automatic logic [6:0] f_crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  // rise/fall are the cycles in which sd_clock toggles
  assign w_tc   = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_rise = w_tc & ~r_sdclk;
  assign w_fall = w_tc & r_sdclk;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div   <= '0;
      r_sdclk <= 1'b0;
    end else if (w_tc) begin
      r_div   <= '0;
      r_sdclk <= ~r_sdclk;
    end else begin
      r_div   <= r_div + DIV_W'(1);
    end
  end

  assign w_line   = sd_serial;
  assign w_rx_nxt = {r_rx, w_line};
  // Response bits after the start bit: [46] transmission, [45:8] payload, [7:1] CRC, [0] end
  assign w_rx_err = (f_crc7({1'b0, w_rx_nxt[46:8]}) != w_rx_nxt[7:1]) | w_rx_nxt[46] | ~w_rx_nxt[0];

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_ev    = 1'b0;
    case (r_state)
      S_IDLE: if (cmd_start) w_state_nxt = S_SEND;
      S_SEND: begin
        w_cnt_ev = w_fall;
        if (w_fall && r_cnt == CNT_W'(48)) w_state_nxt = r_expect ? S_WAIT : S_GAP;
      end
      S_WAIT: begin
        w_cnt_ev = w_rise;
        if (w_rise) begin
          if (!w_line)                                  w_state_nxt = S_RECV;
          else if (r_cnt == CNT_W'(RESP_TIMEOUT - 1))   w_state_nxt = S_GAP;
        end
      end
      S_RECV: begin
        w_cnt_ev = w_rise;
        if (w_rise && r_cnt == CNT_W'(46)) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        w_cnt_ev = w_rise;
        if (w_rise && r_cnt == CNT_W'(GAP_CYCLES - 1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt       <= '0;
      r_frame     <= '0;
      r_expect    <= 1'b0;
      r_oe        <= 1'b0;
      r_out       <= 1'b1;
      r_rx        <= '0;
      r_resp_data <= '0;
      r_strobe    <= 1'b0;
      r_crc_err   <= 1'b0;
      r_tmo       <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_tmo    <= 1'b0;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_cnt_ev)          r_cnt <= r_cnt + CNT_W'(1);
      case (r_state)
        S_IDLE: if (cmd_start) begin
          r_frame  <= {2'b01, cmd_index, cmd_arg, f_crc7({2'b01, cmd_index, cmd_arg}), 1'b1};
          r_expect <= cmd_expect_resp;
        end
        S_SEND: if (w_fall) begin
          if (r_cnt == CNT_W'(48)) begin
            r_oe  <= 1'b0;
            r_out <= 1'b1;
          end else begin
            r_oe    <= 1'b1;
            r_out   <= r_frame[47];
            r_frame <= {r_frame[46:0], 1'b0};
          end
        end
        S_WAIT: if (w_rise && w_line && r_cnt == CNT_W'(RESP_TIMEOUT - 1)) r_tmo <= 1'b1;
        S_RECV: if (w_rise) begin
          r_rx <= w_rx_nxt[45:0];
          if (r_cnt == CNT_W'(46)) begin
            r_resp_data <= w_rx_nxt[45:8];
            r_strobe    <= 1'b1;
            r_crc_err   <= w_rx_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign sd_serial      = r_oe ? r_out : 1'bz;
  assign sd_clock       = r_sdclk;
  assign busy           = (r_state != S_IDLE);
  assign resp_data      = r_resp_data;
  assign resp_strobe    = r_strobe;
  assign resp_crc_error = r_crc_err;
  assign resp_timeout   = r_tmo;
endmodule

// File: tb/tb_sdio_host_cmd.sv
// Directed bench for sdio_host_cmd: table of command/response vectors plus
// hand-written sequences for reset mid-frame and ignored start strobes.
`timescale 1ns/1ps
module tb_sdio_host_cmd;
  localparam int CLK_DIV      = 4;
  localparam int RESP_TIMEOUT = 64;
  localparam int GAP_CYCLES   = 8;
  localparam int NV           = 9;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_expect_resp;
  logic        busy;
  logic [37:0] resp_data;
  logic        resp_strobe;
  logic        resp_crc_error;
  logic        resp_timeout;
  logic        sd_clock;
  wire         sd_serial;

  logic card_oe  = 1'b0;
  logic card_bit = 1'b1;
  assign sd_serial = card_oe ? card_bit : 1'bz;
  pullup (sd_serial);

  always #5 clock = ~clock;

  sdio_host_cmd #(
    .CLK_DIV(CLK_DIV), .RESP_TIMEOUT(RESP_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .cmd_expect_resp(cmd_expect_resp), .busy(busy),
    .resp_data(resp_data), .resp_strobe(resp_strobe), .resp_crc_error(resp_crc_error),
    .resp_timeout(resp_timeout), .sd_clock(sd_clock), .sd_serial(sd_serial)
  );

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        resp;
    logic        card;
    logic [47:0] reply;
    logic [47:0] tx;
    logic        strobe;
    logic        tmo;
    logic        err;
    logic [37:0] data;
  } vec_t;
  vec_t vt [NV];

  int n_vec = 0;
  int n_bad = 0;

  int   rise_cnt = 0;
  int   n_strobe = 0;
  int   n_tmo    = 0;
  int   t_strobe = 0;
  int   t_tmo    = 0;
  int   t_bfall  = 0;
  logic last_err = 1'b0;
  logic busy_q   = 1'b0;

  always @(posedge sd_clock) rise_cnt <= rise_cnt + 1;

  always @(negedge clock) begin
    if (resp_strobe) begin
      n_strobe <= n_strobe + 1;
      t_strobe <= rise_cnt;
      last_err <= resp_crc_error;
    end
    if (resp_timeout) begin
      n_tmo <= n_tmo + 1;
      t_tmo <= rise_cnt;
    end
    if (busy_q && !busy) t_bfall <= rise_cnt;
    busy_q <= busy;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic resp);
    @(negedge clock);
    cmd_index = idx; cmd_arg = arg; cmd_expect_resp = resp; cmd_start = 1'b1;
    @(negedge clock);
    cmd_start = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'(1));
  endtask

  task automatic pulse_start;
    @(negedge clock);
    cmd_index = 6'd0; cmd_arg = 32'hFFFF_FFFF; cmd_expect_resp = 1'b1; cmd_start = 1'b1;
    @(negedge clock);
    cmd_start = 1'b0;
  endtask

  task automatic capture_tx(input int nbits, output logic [47:0] f, output int t_last);
    bit seen;
    seen = 0; f = '0; t_last = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge sd_clock); #1;
      if (sd_serial === 1'b0) seen = 1;
    end
    chk("tx_start_bit", 64'(seen), 64'(1));
    if (seen) begin
      for (int b = 1; b < nbits; b++) begin
        @(posedge sd_clock); #1;
        f = {f[46:0], sd_serial};
      end
      t_last = rise_cnt;
    end
  endtask

  task automatic card_reply(input logic [47:0] r, input int k);
    @(negedge sd_clock);
    repeat (k) @(negedge sd_clock);
    for (int i = 47; i >= 0; i--) begin
      card_oe = 1'b1; card_bit = r[i];
      @(negedge sd_clock);
    end
    card_oe = 1'b0; card_bit = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy && i < 3000) begin
      @(negedge clock);
      i++;
    end
    chk(name, 64'(busy), 64'(0));
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] f;
    int          tl;
    int          s0;
    int          m0;

    vt[0] = '{6'd0,  32'h0,        1'b0, 1'b0, 48'h0,            48'h400000000095, 1'b0, 1'b0, 1'b0, 38'h0};
    vt[1] = '{6'd8,  32'h000001AA, 1'b1, 1'b1, 48'h08000001AA13, 48'h48000001AA87, 1'b1, 1'b0, 1'b0, 38'h08000001AA};
    vt[2] = '{6'd8,  32'h000001AA, 1'b1, 1'b1, 48'h08000001AA15, 48'h48000001AA87, 1'b1, 1'b0, 1'b1, 38'h08000001AA};
    vt[3] = '{6'd55, 32'h0,        1'b1, 1'b1, 48'h3700000000F1, 48'h770000000065, 1'b1, 1'b0, 1'b0, 38'h3700000000};
    vt[4] = '{6'd8,  32'h000001AA, 1'b1, 1'b1, 48'h08000001AA12, 48'h48000001AA87, 1'b1, 1'b0, 1'b1, 38'h08000001AA};
    vt[5] = '{6'd58, 32'h0,        1'b1, 1'b1, 48'h3A0000000069, 48'h7A00000000FD, 1'b1, 1'b0, 1'b0, 38'h3A00000000};
    vt[6] = '{6'd8,  32'h000001AA, 1'b1, 1'b1, 48'h48000001AA87, 48'h48000001AA87, 1'b1, 1'b0, 1'b1, 38'h08000001AA};
    vt[7] = '{6'd8,  32'h000001AA, 1'b1, 1'b0, 48'h0,            48'h48000001AA87, 1'b0, 1'b1, 1'b0, 38'h08000001AA};
    vt[8] = '{6'd41, 32'h40000000, 1'b0, 1'b0, 48'h0,            48'h694000000077, 1'b0, 1'b0, 1'b0, 38'h08000001AA};

    // reset held together with a start strobe
    reset = 1'b1; cmd_start = 1'b1; cmd_index = 6'd8; cmd_arg = 32'h1AA; cmd_expect_resp = 1'b1;
    repeat (4) @(negedge clock);
    chk("rst_sd_clock",  64'(sd_clock),       64'(0));
    chk("rst_busy",      64'(busy),           64'(0));
    chk("rst_strobe",    64'(resp_strobe),    64'(0));
    chk("rst_timeout",   64'(resp_timeout),   64'(0));
    chk("rst_crc_error", 64'(resp_crc_error), 64'(0));
    chk("rst_resp_data", 64'(resp_data),      64'(0));
    chk("rst_line_idle", 64'(sd_serial),      64'(1));
    reset = 1'b0; cmd_start = 1'b0;
    @(negedge clock);
    chk("busy_after_rst_start", 64'(busy), 64'(0));
    repeat (20) @(negedge clock);

    for (int v = 0; v < NV; v++) begin
      s0 = n_strobe;
      m0 = n_tmo;
      start_cmd(vt[v].idx, vt[v].arg, vt[v].resp);
      capture_tx(48, f, tl);
      chk($sformatf("v%0d_tx_frame", v), 64'(f), 64'(vt[v].tx));
      if (vt[v].card) card_reply(vt[v].reply, 5);
      wait_idle($sformatf("v%0d_busy_drop", v));
      chk($sformatf("v%0d_strobes", v),  64'(n_strobe - s0), 64'(vt[v].strobe));
      chk($sformatf("v%0d_timeouts", v), 64'(n_tmo - m0),    64'(vt[v].tmo));
      if (vt[v].strobe) begin
        chk($sformatf("v%0d_crc_error", v),   64'(last_err),      64'(vt[v].err));
        chk($sformatf("v%0d_strobe_time", v), 64'(t_strobe - tl), 64'(53));
        chk($sformatf("v%0d_gap_time", v),    64'(t_bfall - t_strobe), 64'(GAP_CYCLES));
      end else if (vt[v].tmo) begin
        chk($sformatf("v%0d_timeout_time", v), 64'(t_tmo - tl),      64'(RESP_TIMEOUT));
        chk($sformatf("v%0d_gap_time", v),     64'(t_bfall - t_tmo), 64'(GAP_CYCLES));
      end else begin
        chk($sformatf("v%0d_gap_time", v), 64'(t_bfall - tl), 64'(GAP_CYCLES));
      end
      chk($sformatf("v%0d_resp_data", v), 64'(resp_data), 64'(vt[v].data));
      repeat (10) @(negedge clock);
    end

    // reset while bit 20 (a 0 in CMD0) is on the line
    start_cmd(6'd0, 32'h0, 1'b0);
    capture_tx(21, f, tl);
    chk("mid_reset_partial_frame", 64'(f[20:0]), 64'(21'h080000));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_reset_busy",      64'(busy),      64'(0));
    chk("mid_reset_sd_clock",  64'(sd_clock),  64'(0));
    chk("mid_reset_line",      64'(sd_serial), 64'(1));
    chk("mid_reset_resp_data", 64'(resp_data), 64'(0));
    repeat (20) @(negedge clock);
    start_cmd(6'd0, 32'h0, 1'b0);
    capture_tx(48, f, tl);
    chk("post_reset_tx_frame", 64'(f), 64'(48'h400000000095));
    wait_idle("post_reset_busy_drop");
    chk("post_reset_gap_time", 64'(t_bfall - tl), 64'(GAP_CYCLES));
    repeat (10) @(negedge clock);

    // start strobes during SEND and GAP must be ignored
    m0 = n_tmo;
    s0 = n_strobe;
    start_cmd(6'd55, 32'h0, 1'b0);
    fork
      capture_tx(48, f, tl);
      begin
        repeat (80) @(negedge clock);
        pulse_start();
      end
    join
    chk("ignore_tx_frame", 64'(f), 64'(48'h770000000065));
    repeat (3) @(posedge sd_clock);
    @(negedge clock);
    chk("ignore_busy_in_gap", 64'(busy), 64'(1));
    pulse_start();
    wait_idle("ignore_busy_drop");
    chk("ignore_gap_time", 64'(t_bfall - tl),   64'(GAP_CYCLES));
    repeat (40) @(negedge clock);
    chk("ignore_stays_idle", 64'(busy),         64'(0));
    chk("ignore_no_timeout", 64'(n_tmo - m0),   64'(0));
    chk("ignore_no_strobe",  64'(n_strobe - s0), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sdio_host_cmd.md
# sdio_host_cmd

Host-side SDIO command-line engine: generates `sd_clock`, serialises a 48-bit command frame with CRC7 onto the CMD line, then optionally captures and checks the 48-bit R-type response from the card. It is the initiator counterpart of the card-side command stream receive/response pair. It is used as the bench-side driver for the slave and as the command path of a host-side controller.

## Interface
- `CLK_DIV`, 4: system clocks per `sd_clock` half-period, at least 2; `sd_clock` = `clock`/(2·`CLK_DIV`).
- `RESP_TIMEOUT`, 64: `sd_clock` rising edges to wait for a response start bit.
- `GAP_CYCLES`, 8: idle `sd_clock` periods enforced after each transaction.

Ports:
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `cmd_start`  in  1  one-cycle request strobe; accepted only while `busy`=0.
- `cmd_index`  in  6  command index, sampled on acceptance.
- `cmd_arg`  in  32  command argument, sampled on acceptance.
- `cmd_expect_resp`  in  1  1 = collect a 48-bit response; sampled on acceptance.
- `busy`  out  1  high from acceptance until the gap completes.
- `resp_data`  out  38  {index[5:0], arg[31:0]} of the last response; holds its value between responses.
- `resp_strobe`  out  1  one-cycle pulse when `resp_data` is updated.
- `resp_crc_error`  out  1  valid with `resp_strobe`; CRC, transmission-bit or end-bit error.
- `resp_timeout`  out  1  one-cycle pulse when no start bit arrives.
- `sd_clock`  out  1  SD clock.
- `sd_serial`  inout  1  CMD line; driven only while sending, otherwise `1'bz` (external pull-up).

## Operation
- Divider: a free-running counter 0..`CLK_DIV`-1 toggles `sd_clock` at its terminal count. It produces internal one-cycle `rise`/`fall` events coincident with the toggle.
- Host changes CMD on `fall` and samples CMD on `rise`.
- Tx frame, MSB first: start 0, transmission 1, index[5:0], arg[31:0], CRC7[6:0], end 1 (48 bits).
- CRC7 polynomial is x^7+x^3+1 with initial value 0, computed over the first 40 bits.
- Rx frame: start 0, transmission 0, index[5:0], arg[31:0], CRC7, end 1.
- CRC7 is checked over the first 40 received bits.
- `resp_crc_error` = CRC mismatch OR transmission bit ≠ 0 OR end bit ≠ 1.
- States:
  - IDLE: on `cmd_start`, latch inputs, go to SEND.
  - SEND: on each `fall`, drive the next bit with output enable on. On the `fall` after the end bit, release the line and go to WAIT_START if `cmd_expect_resp`, else go to GAP.
  - WAIT_START: on each `rise`, if CMD=0, go to RECV; else increment the timeout counter. When the counter reaches `RESP_TIMEOUT`, pulse `resp_timeout` and go to GAP.
  - RECV: shift 47 further bits on `rise`. After the end bit, update `resp_data`, pulse `resp_strobe`, set `resp_crc_error`, go to GAP.
  - GAP: count `GAP_CYCLES` `rise` events, then go to IDLE and drop `busy`.
- `cmd_start` while `busy`=1 is ignored with no side effects.
- `reset` with `cmd_start` in the same cycle: `reset` wins.

## Timing
- Reset values:
  - `sd_clock`=0, divider=0, state=IDLE.
  - `busy`=0, `resp_strobe`=0, `resp_timeout`=0, `resp_crc_error`=0, `resp_data`=0.
  - Output enable 0, driven bit 1.
- `busy` rises the cycle after the accepting `cmd_start`.
- The start bit appears at the first `fall` after acceptance.
- Each bit is held exactly 2·`CLK_DIV` clocks.
- Output enable drops on the `fall` that ends the end-bit period, i.e. 48 `sd_clock` periods after the first bit.
- Response sampling starts at the first `rise` after release.
- `resp_strobe`, `resp_crc_error` and the new `resp_data` are all valid in the clock cycle after the `rise` that samples the response end bit.
- `busy` falls `GAP_CYCLES` `rise` events after response completion, timeout, or release of a no-response command.
- Reset mid-transaction:
  - The line is released, `sd_clock` is 0 and `busy` is 0 on the cycle after `reset`.
  - A partial response never raises `resp_strobe`.
  - `resp_data` returns to 0.
- The timeout counter and bit counter are cleared on every state entry; no wrap-around is possible.

## Test plan
- CMD0, arg 0x00000000, no response, CLK_DIV=4 → CMD carries 0x400000000095, `busy` falls after 48+8 `sd_clock` periods, no `resp_strobe` or `resp_timeout`.
- CMD8, arg 0x000001AA, card model replies 0x08000001AA13 after 5 clocks → Tx 0x48000001AA87; `resp_data`={6'd8,32'h000001AA}, `resp_crc_error`=0, single `resp_strobe`.
- Same as above but the reply CRC byte is 0x15 (or end bit 0) → `resp_strobe` with `resp_crc_error`=1.
- CMD8 with the line left high → `resp_timeout` pulses exactly at the 64th `rise` after release, no `resp_strobe`, `busy` falls 8 periods later.
- `reset` asserted at bit 20 of SEND → line is Z and `busy`=0 on the next cycle. A following CMD0 is transmitted bit-exact.
- Second `cmd_start` issued mid-SEND and mid-GAP → ignored; the frame on CMD is unchanged.
